// File: rtl/apb_char_ram_writer.sv
// apb_char_ram_writer: APB-written character RAM with a free-running 1-cycle-latency video read port.
// Define APB_CHAR_RAM_READBACK_EN to add a one-wait-state APB read path through a second read port.
module apb_char_ram_writer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk_i,
    input  logic                  arstn_i,
    input  logic                  psel_i,
    input  logic                  penable_i,
    input  logic                  pwrite_i,
    input  logic [31:0]           paddr_i,
    input  logic [31:0]           pwdata_i,
    output logic [31:0]           prdata_o,
    output logic                  pready_o,
    output logic                  pslverr_o,
    input  logic [ADDR_WIDTH-1:0] vid_addr_i,
    output logic [DATA_WIDTH-1:0] vid_dout_o
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] vid_q;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  access;
    logic                  in_range;
    logic                  idle;
    logic                  wr_en;
    logic                  unused_bits;

    assign idx         = paddr_i[ADDR_WIDTH+1:2];
    assign in_range    = ~|paddr_i[31:ADDR_WIDTH+2];
    assign access      = arstn_i & psel_i & penable_i;
    assign wr_en       = access & idle & pwrite_i & in_range;
    assign unused_bits = ^{paddr_i[1:0], pwdata_i};
    assign vid_dout_o  = vid_q;

    // APB write port; memory is deliberately never reset
    always_ff @(posedge clk_i) begin
        if (wr_en) mem[idx] <= pwdata_i[DATA_WIDTH-1:0];
    end

    // video read port, read-first against a same-edge APB write
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) vid_q <= '0;
        else          vid_q <= mem[vid_addr_i];
    end

`ifdef APB_CHAR_RAM_READBACK_EN
    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DONE} state_t;
    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] rd_q;

    assign idle = state_q == IDLE;

    // FSM state register
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // APB read port, captured when a read is issued; prdata_o masks it otherwise
    always_ff @(posedge clk_i) begin
        if (access & idle & ~pwrite_i & in_range) rd_q <= mem[idx];
    end

    // next state and APB response: writes/errors complete in IDLE, reads one cycle later
    always_comb begin
        state_d   = state_q;
        pready_o  = 1'b0;
        pslverr_o = 1'b0;
        prdata_o  = '0;
        case (state_q)
            IDLE: begin
                if (access) begin
                    pready_o  = pwrite_i | ~in_range;
                    pslverr_o = ~in_range;
                    state_d   = (~pwrite_i & in_range) ? RD_WAIT : IDLE;
                end
            end
            RD_WAIT: begin
                pready_o = access;
                prdata_o = access ? 32'(rd_q) : '0;
                state_d  = access ? RD_DONE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
`else
    assign idle = 1'b1;

    // every transfer is zero-wait; reads and out-of-range accesses report an error
    always_comb begin
        pready_o  = access;
        pslverr_o = access & (~in_range | ~pwrite_i);
        prdata_o  = '0;
    end
`endif
endmodule

// File: tb/tb_apb_char_ram_writer.sv
// tb_apb_char_ram_writer: directed APB/video stimulus with queued expectations checked by a negedge monitor.
module tb_apb_char_ram_writer;
    localparam int DW = 8;
    localparam int AW = 12;

    typedef struct packed {
        logic [31:0] rd;
        logic        err;
        logic [3:0]  waits;
    } resp_t;

    logic          clk_i = 0;
    logic          arstn_i = 0;
    logic          psel_i = 0;
    logic          penable_i = 0;
    logic          pwrite_i = 0;
    logic [31:0]   paddr_i = 0;
    logic [31:0]   pwdata_i = 0;
    logic [31:0]   prdata_o;
    logic          pready_o;
    logic          pslverr_o;
    logic [AW-1:0] vid_addr_i = 0;
    logic [DW-1:0] vid_dout_o;

    resp_t         sb[$];
    logic [DW-1:0] vq[$];
    logic          vid_chk = 0;
    logic [3:0]    waits = 0;
    int            checks = 0;
    int            errors = 0;

    apb_char_ram_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk_i(clk_i), .arstn_i(arstn_i), .psel_i(psel_i), .penable_i(penable_i),
        .pwrite_i(pwrite_i), .paddr_i(paddr_i), .pwdata_i(pwdata_i), .prdata_o(prdata_o),
        .pready_o(pready_o), .pslverr_o(pslverr_o), .vid_addr_i(vid_addr_i), .vid_dout_o(vid_dout_o)
    );

    always #5 clk_i = ~clk_i;

    // monitor: APB completions against the response queue, video data against the video queue
    always @(negedge clk_i) begin
        resp_t         e;
        logic [DW-1:0] v;
        checks++;
        if (pready_o) begin
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pready addr=%h prdata=%h pslverr=%b", paddr_i, prdata_o, pslverr_o);
            end else begin
                e = sb.pop_front();
                if (prdata_o !== e.rd || pslverr_o !== e.err || waits !== e.waits) begin
                    errors++;
                    $display("FAIL apb_resp addr=%h got prdata=%h pslverr=%b waits=%0d expected prdata=%h pslverr=%b waits=%0d",
                             paddr_i, prdata_o, pslverr_o, waits, e.rd, e.err, e.waits);
                end
            end
        end else if (prdata_o !== 32'h0) begin
            errors++;
            $display("FAIL prdata_not_ready got %h expected 00000000", prdata_o);
        end
        waits = (pready_o || !(psel_i && penable_i)) ? 4'd0 : waits + 4'd1;
        if (vid_chk) begin
            checks++;
            if (vq.size() == 0) begin
                errors++;
                $display("FAIL vid_no_expectation addr=%0d", vid_addr_i);
            end else begin
                v = vq.pop_front();
                if (vid_dout_o !== v) begin
                    errors++;
                    $display("FAIL vid_dout addr=%0d got %h expected %h", vid_addr_i, vid_dout_o, v);
                end
            end
        end
    end

    task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [31:0] rd, input logic err, input logic [3:0] w);
        int n = 0;
        sb.push_back('{rd, err, w});
        psel_i = 1; penable_i = 0; pwrite_i = wr; paddr_i = addr; pwdata_i = data;
        @(posedge clk_i); #1;
        penable_i = 1;
        @(negedge clk_i);
        while (!pready_o && n < 6) begin
            @(negedge clk_i);
            n++;
        end
        checks++;
        if (!pready_o) begin
            errors++;
            $display("FAIL apb_timeout addr=%h got no pready expected pready within 6 cycles", addr);
            void'(sb.pop_front());
        end
        @(posedge clk_i); #1;
        psel_i = 0; penable_i = 0;
    endtask

    task automatic vid_expect(input logic [AW-1:0] a, input logic [DW-1:0] v);
        vid_addr_i = a;
        @(posedge clk_i); #1;
        vq.push_back(v);
        vid_chk = 1;
        @(posedge clk_i); #1;
        vid_chk = 0;
    endtask

    task automatic chk_reset(input string tag);
        checks++;
        if (pready_o !== 0 || pslverr_o !== 0 || prdata_o !== 0 || vid_dout_o !== 0) begin
            errors++;
            $display("FAIL %s got pready=%b pslverr=%b prdata=%h vid=%h expected all 0",
                     tag, pready_o, pslverr_o, prdata_o, vid_dout_o);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1);
    end

    initial begin
        #3 chk_reset("reset_initial");
        repeat (2) @(posedge clk_i);
        #1 chk_reset("reset_held");
        @(negedge clk_i) arstn_i = 1;
        @(posedge clk_i); #1;

        apb(1, 32'h0000_0010, 32'h0000_0041, 32'h0, 1'b0, 4'd0);
        vid_expect(12'd4, 8'h41);
        apb(1, 32'h0000_0000, 32'h0000_00A5, 32'h0, 1'b0, 4'd0);
        vid_expect(12'd0, 8'hA5);
        apb(1, 32'h0000_4000, 32'h0000_0077, 32'h0, 1'b1, 4'd0);
        vid_expect(12'd0, 8'hA5);
        apb(1, 32'h8000_0000, 32'h0000_0066, 32'h0, 1'b1, 4'd0);
        vid_expect(12'd0, 8'hA5);
        apb(1, 32'h0000_0027, 32'hFFFF_FF3C, 32'h0, 1'b0, 4'd0);
        vid_expect(12'd9, 8'h3C);
        apb(1, 32'h0000_3FFC, 32'h0000_0099, 32'h0, 1'b0, 4'd0);
        vid_expect(12'd4095, 8'h99);

        apb(1, 32'h0000_001C, 32'h0000_0041, 32'h0, 1'b0, 4'd0);
        vid_expect(12'd7, 8'h41);
        sb.push_back('{32'h0, 1'b0, 4'd0});
        vid_addr_i = 7;
        psel_i = 1; penable_i = 0; pwrite_i = 1; paddr_i = 32'h0000_001C; pwdata_i = 32'h0000_0055;
        @(posedge clk_i); #1;
        penable_i = 1;
        @(posedge clk_i); #1;
        psel_i = 0; penable_i = 0;
        vq.push_back(8'h41);
        vid_chk = 1;
        @(posedge clk_i); #1;
        vq.push_back(8'h55);
        @(posedge clk_i); #1;
        vid_chk = 0;

        apb(0, 32'h0000_4010, 32'h0, 32'h0, 1'b1, 4'd0);
`ifdef APB_CHAR_RAM_READBACK_EN
        apb(0, 32'h0000_0010, 32'h0, 32'h0000_0041, 1'b0, 4'd1);
        apb(0, 32'h0000_0026, 32'h0, 32'h0000_003C, 1'b0, 4'd1);
        psel_i = 1; penable_i = 0; pwrite_i = 0; paddr_i = 32'h0000_001C;
        @(posedge clk_i); #1;
        penable_i = 1;
        @(posedge clk_i); #1;
        psel_i = 0; penable_i = 0;
        @(posedge clk_i); #1;
        apb(0, 32'h0000_001C, 32'h0, 32'h0000_0055, 1'b0, 4'd1);
        vid_addr_i = 4;
        psel_i = 1; penable_i = 0; pwrite_i = 0; paddr_i = 32'h0000_0010;
        @(posedge clk_i); #1;
        penable_i = 1;
        @(posedge clk_i); #1;
        arstn_i = 0;
        #1 chk_reset("reset_rd_wait");
        psel_i = 0; penable_i = 0;
        repeat (2) @(posedge clk_i);
        #1 chk_reset("reset_rd_wait_held");
        @(negedge clk_i) arstn_i = 1;
        @(posedge clk_i); #1;
        vid_expect(12'd4, 8'h41);
        apb(0, 32'h0000_0010, 32'h0, 32'h0000_0041, 1'b0, 4'd1);
`else
        apb(0, 32'h0000_0010, 32'h0, 32'h0, 1'b1, 4'd0);
        vid_addr_i = 4;
        arstn_i = 0;
        #1 chk_reset("reset_idle");
        repeat (2) @(posedge clk_i);
        @(negedge clk_i) arstn_i = 1;
        @(posedge clk_i); #1;
        vid_expect(12'd4, 8'h41);
        vid_expect(12'd7, 8'h55);
`endif
        repeat (3) @(posedge clk_i);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL apb_leftover got %0d pending responses expected 0", sb.size());
        end
        checks++;
        if (vq.size() != 0) begin
            errors++;
            $display("FAIL vid_leftover got %0d pending video values expected 0", vq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/apb_char_ram_writer.md
APB_CHAR_RAM_WRITER -- requirements
Module: apb_char_ram_writer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the width of a memory word (1..32).
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, the memory word-address width; depth = 2**ADDR_WIDTH words.
REQ-003 SHALL have port clk_i  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port arstn_i  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port psel_i  input  1  APB select.
REQ-006 SHALL have port penable_i  input  1  APB enable (access phase).
REQ-007 SHALL have port pwrite_i  input  1  APB direction; 1 = write.
REQ-008 SHALL have port paddr_i  input  32  APB byte address.
REQ-009 SHALL have port pwdata_i  input  32  APB write data; bits [DATA_WIDTH-1:0] are stored.
REQ-010 SHALL have port prdata_o  output  32  APB read data, zero-extended.
REQ-011 SHALL have port pready_o  output  1  APB transfer complete.
REQ-012 SHALL have port pslverr_o  output  1  APB error; valid only when pready_o=1.
REQ-013 SHALL have port vid_addr_i  input  ADDR_WIDTH  video-side read address.
REQ-014 SHALL have port vid_dout_o  output  DATA_WIDTH  video-side read data.

Function
REQ-015 SHALL hold a 2**ADDR_WIDTH x DATA_WIDTH array; APB is its only write path.
REQ-016 SHALL decode word index = paddr_i[ADDR_WIDTH+1:2]; paddr_i[1:0] are ignored.
REQ-017 SHALL flag out-of-range when any paddr_i[31:ADDR_WIDTH+2] bit is 1; such transfers complete zero-wait with pslverr_o=1, no write, prdata_o=0.
REQ-018 SHALL complete in-range writes zero-wait: pready_o=1 in the first access cycle (psel_i & penable_i), memory updated at that clock edge.
REQ-019 SHALL use FSM states IDLE, RD_WAIT, RD_DONE for in-range reads: IDLE -> RD_WAIT on first access cycle (memory read issued); RD_WAIT -> RD_DONE next cycle, prdata_o = word, pready_o=1; RD_DONE -> IDLE next cycle.
REQ-020 SHALL therefore give in-range reads exactly one wait state (pready_o low in the first access cycle, high in the second).
REQ-021 SHALL drive pready_o=1 for exactly one cycle per transfer, pslverr_o=0 on in-range transfers, and prdata_o=0 whenever pready_o=0.
REQ-022 SHALL abandon a read and return to IDLE with pready_o=0 if psel_i drops in RD_WAIT.
REQ-023 SHALL return vid_dout_o = mem[vid_addr_i] sampled at clock edge N, visible after edge N (1-cycle latency), every cycle, independent of APB activity.
REQ-024 SHALL be read-first on collision: a video read and an APB write to the same word at the same edge returns the old word; the new word is visible from the next read.
REQ-025 SHALL be read-first for the APB read port likewise.

Reset
REQ-026 SHALL while arstn_i=0 force FSM to IDLE and pready_o, pslverr_o, prdata_o, vid_dout_o to 0, asynchronously.
REQ-027 SHALL not clear memory contents on reset; they persist across reset.
REQ-028 SHALL on reset asserted mid-read abort the transfer with no pready_o pulse; after release the next access phase restarts from IDLE.

Configuration
REQ-029 SHALL, with APB_CHAR_RAM_READBACK_EN defined, implement APB reads per REQ-019..REQ-021 and REQ-025 using a second synchronous read port.
REQ-030 SHALL, without APB_CHAR_RAM_READBACK_EN, omit the APB read port and FSM read states; APB reads complete zero-wait with prdata_o=0, pslverr_o=1; writes and video port are unchanged.

Verification
REQ-031 SHALL cover: APB write 0x41 to paddr 0x0000_0010, then vid_addr_i=4 -> vid_dout_o=0x41 one cycle later.
REQ-032 SHALL cover: APB read paddr 0x10 (READBACK_EN) -> pready_o low in first access cycle, high in second, prdata_o=0x0000_0041, pslverr_o=0.
REQ-033 SHALL cover: APB write to paddr 0x0000_4000 (ADDR_WIDTH=12) -> zero-wait pready_o=1, pslverr_o=1, word 0 unchanged.
REQ-034 SHALL cover: same-edge APB write 0x55 to word 7 and vid_addr_i=7 holding 0x41 -> vid_dout_o=0x41, then 0x55 next cycle.
REQ-035 SHALL cover: arstn_i low during RD_WAIT -> all outputs 0 immediately, no pready_o pulse, memory word 4 still 0x41 after release.
REQ-036 SHALL cover: macro undefined, APB read paddr 0x10 -> zero-wait pready_o=1, pslverr_o=1, prdata_o=0.
